bin_to_bcd_seq: RTL

//  Sequential binary-to-BCD converter. Takes a signed result word and produces four

---
 rtl/bin_to_bcd_seq.sv | 120 ++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential signed binary to 4-digit BCD converter (double dabble, one bit per clock).
// Latency: W clocks from the accepted start edge to done/outputs.
// Backpressure: start is ignored while busy; digit outputs change only with done.
module bin_to_bcd_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] din,
  output logic         busy,
  output logic         done,
  output logic         neg,
  output logic         ovf,
  output logic [3:0]   dig3,
  output logic [3:0]   dig2,
  output logic [3:0]   dig1,
  output logic [3:0]   dig0
);

  localparam int CW = $clog2(W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  mag;
  logic [W-1:0]  mag_in;
  logic [15:0]   bcd;
  logic [15:0]   bcd_adj;
  logic [15:0]   bcd_shf;
  logic          sign_r;
  logic          sat_r;
  logic          sat_in;
  logic          last;

  // Magnitude of the incoming word; the most negative value maps to 2^(W-1) unsigned.
  always_comb begin
    mag_in = din[W-1] ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;
    sat_in = ({{(32-W){1'b0}}, mag_in} > 32'd9999);
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next magnitude bit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    bcd_shf = {bcd_adj[14:0], mag[W-1]};
    last    = (state == SHIFT) && (cnt == CW'(W-1));
  end

  // Next-state logic: a start in IDLE begins a W-step shift sequence.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: capture on start, shift during SHIFT, publish results on the last shift.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt    <= '0;
      mag    <= '0;
      bcd    <= '0;
      sign_r <= 1'b0;
      sat_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      dig3   <= 4'd0;
      dig2   <= 4'd0;
      dig1   <= 4'd0;
      dig0   <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_r <= din[W-1];
            mag    <= mag_in;
            sat_r  <= sat_in;
            bcd    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          bcd <= bcd_shf;
          mag <= {mag[W-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (last) begin
            dig3 <= sat_r ? 4'd9 : bcd_shf[15:12];
            dig2 <= sat_r ? 4'd9 : bcd_shf[11:8];
            dig1 <= sat_r ? 4'd9 : bcd_shf[7:4];
            dig0 <= sat_r ? 4'd9 : bcd_shf[3:0];
            neg  <= sign_r;
            ovf  <= sat_r;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
